// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the next-PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_RAS_DEPTH = 4;
  localparam int unsigned DEF_RESET_PC  = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty leaves the stack unchanged. ovf/unf flag those
// two cases combinationally for the current request.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_MAX);
  assign ovf   = push && full;
  assign unf   = pop && empty;
  assign top   = mem_q[wr_ptr_q - PTR_ONE];

  // Write pointer always names the next free slot; when full it names the oldest.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
      if (!full) count_d = count_q + CNT_ONE;
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
  end

  // Stack state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: increment/jump/call/return selection, stall and fetch
// back-pressure hold, halt/resume. Define PC_SEQ_RAS_EN to build the
// return-address stack; otherwise calls behave as jumps and every return
// falls through to pc+1 with an error pulse.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
  parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              call_en,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret_en,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_valid,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ras_err_q, ras_err_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              advance;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty_w, ras_full_w, ras_ovf, ras_unf;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign advance = (state_q == RUN) && imem_ready && !stall;

`ifdef PC_SEQ_RAS_EN
  pc_ras #(
    .ADDR_W(ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty_w),
    .full     (ras_full_w),
    .ovf      (ras_ovf),
    .unf      (ras_unf)
  );
`else
  // Stackless build: permanently empty, so every return underflows.
  assign ras_top     = '0;
  assign ras_empty_w = 1'b1;
  assign ras_full_w  = 1'b0;
  assign ras_ovf     = 1'b0;
  assign ras_unf     = ras_pop;
  logic unused_ok;
  assign unused_ok = ^{ras_push, 1'(RAS_DEPTH)};
`endif

  // State transitions and prioritised next-PC selection (ret > call > jump > +1).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    if (resume) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (advance) begin
      if (ret_en) begin
        ras_pop = 1'b1;
        pc_d    = ras_empty_w ? pc_inc : ras_top;
      end else if (call_en) begin
        ras_push = 1'b1;
        pc_d     = call_addr;
      end else if (jump_en) begin
        pc_d = jump_addr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Error pulse for an overflowing call or underflowing return.
  always_comb begin
    ras_err_d = ras_ovf | ras_unf;
  end

  // PC, state and error-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= BOOT;
      pc_q      <= ADDR_W'(RESET_PC);
      ras_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ras_err_q <= ras_err_d;
    end
  end

  assign pc_out      = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign ras_empty   = ras_empty_w;
  assign ras_full    = ras_full_w;
  assign ras_err     = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural model predicts the outputs of every
// cycle into a scoreboard queue; each scenario task pops and compares.
// Expectations follow the PC_SEQ_RAS_EN setting of the build.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          stall, halt, resume, jump_en, call_en, ret_en, imem_ready;
  logic [AW-1:0] jump_addr, call_addr;
  logic [AW-1:0] pc_out;
  logic          fetch_valid, halted, ras_empty, ras_full, ras_err;

  pc_sequencer #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .halt(halt), .resume(resume),
    .jump_en(jump_en), .jump_addr(jump_addr), .call_en(call_en), .call_addr(call_addr),
    .ret_en(ret_en), .imem_ready(imem_ready), .pc_out(pc_out), .fetch_valid(fetch_valid),
    .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef logic [AW+4:0] obs_t;  // {pc, fetch_valid, halted, empty, full, err}
  obs_t obs;
  assign obs = {pc_out, fetch_valid, halted, ras_empty, ras_full, ras_err};

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // Model: 0 = boot, 1 = run, 2 = halt; stack as a queue, newest at the back.
  int            m_state;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_stk[$];
  logic          m_err;

  function automatic obs_t pack_exp();
    return {m_pc, m_state == 1, m_state == 2, m_stk.size() == 0,
            m_stk.size() == int'(DEPTH), m_err};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_err = 1'b0; m_stk.delete(); exp_q.delete();
  endtask

  task automatic model_step();
    logic          adv;
    logic [AW-1:0] inc;
    adv   = (m_state == 1) && imem_ready && !stall;
    inc   = m_pc + 16'd1;
    m_err = 1'b0;
    if (adv) begin
      if (ret_en) begin
        if (RAS && m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = inc; m_err = 1'b1; end
      end else if (call_en) begin
        if (RAS) begin
          if (m_stk.size() == int'(DEPTH)) begin m_stk.delete(0); m_err = 1'b1; end
          m_stk.push_back(inc);
        end
        m_pc = call_addr;
      end else if (jump_en) m_pc = jump_addr;
      else m_pc = inc;
    end
    case (m_state)
      0: m_state = 1;
      1: if (halt) m_state = 2;
      default: if (resume) m_state = 1;
    endcase
    exp_q.push_back(pack_exp());
  endtask

  task automatic set_idle();
    stall = 0; halt = 0; resume = 0; jump_en = 0; call_en = 0; ret_en = 0;
    jump_addr = '0; call_addr = '0; imem_ready = 1;
  endtask

  // Predict, then let one clock edge happen and settle.
  task automatic tick();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [AW-1:0] seq [4];
    obs_t e;
    seq = '{16'd0, 16'd1, 16'd2, 16'd3};
    set_idle(); reset_n = 0; model_reset();
    #2;
    checks++;
    if (obs !== {16'h0000, 5'b00100}) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs, {16'h0000, 5'b00100});
    end
    @(posedge clk); #1; reset_n = 1; #1;
    checks++;
    if (pc_out !== 16'd0 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL boot_cycle: pc %h fv %b want 0000/0", pc_out, fetch_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_seq[%0d]: got %h want %h", i, obs, e); end
      checks++;
      if (pc_out !== seq[i] || fetch_valid !== 1'b1) begin
        errors++; $display("FAIL first_fetch[%0d]: pc %h fv %b want %h/1", i, pc_out, fetch_valid, seq[i]);
      end
    end
  endtask

  task automatic test_hold();
    obs_t e;
    for (int i = 0; i < 10; i++) begin
      set_idle();
      case (i)
        0, 5:    begin jump_en = 1; jump_addr = 16'h0005; end
        1, 2, 3: imem_ready = 0;
        6, 7, 8: stall = 1;
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hold[%0d]: got %h want %h", i, obs, e); end
      if (i == 4 || i == 9) begin
        checks++;
        if (pc_out !== 16'h0006) begin errors++; $display("FAIL hold_release[%0d]: pc %h want 0006", i, pc_out); end
      end
    end
  endtask

  task automatic test_call_ret();
    obs_t e;
    logic [AW-1:0] want_ret;
    want_ret = RAS ? 16'h0011 : 16'h0041;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      case (i)
        0: begin jump_en = 1; jump_addr = 16'h0010; end
        1: begin call_en = 1; call_addr = 16'h0040; end
        default: ret_en = 1;
      endcase
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL call_ret[%0d]: got %h want %h", i, obs, e); end
    end
    checks++;
    if (pc_out !== want_ret || ras_empty !== 1'b1) begin
      errors++; $display("FAIL ret_target: pc %h empty %b want %h/1", pc_out, ras_empty, want_ret);
    end
  endtask

  task automatic test_overflow();
    obs_t e;
    for (int i = 0; i < 13; i++) begin
      set_idle();
      case (i)
        0: begin jump_en = 1; jump_addr = 16'h0100; end
        1, 2, 3, 4, 5: begin call_en = 1; call_addr = 16'((i + 1) << 8); end
        6, 12: ;
        default: ret_en = 1;
      endcase
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL overflow[%0d]: got %h want %h", i, obs, e); end
      if (i == 5) begin
        checks++;
        if (ras_err !== RAS || ras_full !== RAS) begin
          errors++; $display("FAIL fifth_call: err %b full %b want %b/%b", ras_err, ras_full, RAS, RAS);
        end
      end
      if (i == 11) begin
        checks++;
        if (pc_out !== (RAS ? 16'h0202 : 16'h0606) || ras_err !== 1'b1) begin
          errors++; $display("FAIL underflow_ret: pc %h err %b want %h/1", pc_out, ras_err,
                             RAS ? 16'h0202 : 16'h0606);
        end
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      case (i)
        0, 2: begin jump_en = 1; jump_addr = 16'hFFFF; end
        3:    begin call_en = 1; call_addr = 16'h0030; end
        4:    ret_en = 1;
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL wrap[%0d]: got %h want %h", i, obs, e); end
      if (i == 1 || i == 4) begin
        checks++;
        if (pc_out !== ((i == 1 || RAS) ? 16'h0000 : 16'h0031)) begin
          errors++; $display("FAIL wrap_pc[%0d]: pc %h", i, pc_out);
        end
      end
    end
  endtask

  task automatic test_priority();
    obs_t e;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      case (i)
        0: begin jump_en = 1; jump_addr = 16'h0020; end
        1: begin call_en = 1; call_addr = 16'h0050; end
        2: begin call_en = 1; call_addr = 16'h0060; end
        3: begin ret_en = 1; call_en = 1; call_addr = 16'h0070; jump_en = 1; jump_addr = 16'h0080; end
        default: ret_en = 1;
      endcase
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL priority[%0d]: got %h want %h", i, obs, e); end
      if (i == 3) begin
        checks++;
        if (pc_out !== (RAS ? 16'h0051 : 16'h0061)) begin
          errors++; $display("FAIL ret_wins: pc %h want %h", pc_out, RAS ? 16'h0051 : 16'h0061);
        end
      end
    end
  endtask

  task automatic test_halt();
    obs_t e;
    for (int i = 0; i < 9; i++) begin
      set_idle();
      case (i)
        0: begin jump_en = 1; jump_addr = 16'h0007; end
        1: halt = 1;
        2: begin halt = 1; jump_en = 1; jump_addr = 16'h0033; end
        4, 7: resume = 1;
        6: begin stall = 1; halt = 1; end
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL halt[%0d]: got %h want %h", i, obs, e); end
      if (i == 3) begin
        checks++;
        if (pc_out !== 16'h0008 || halted !== 1'b1 || fetch_valid !== 1'b0) begin
          errors++; $display("FAIL halt_frozen: pc %h halted %b fv %b want 0008/1/0", pc_out, halted, fetch_valid);
        end
      end
      if (i == 5) begin
        checks++;
        if (pc_out !== 16'h0009 || halted !== 1'b0) begin
          errors++; $display("FAIL resume_pc: pc %h halted %b want 0009/0", pc_out, halted);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    for (int i = 0; i < 80; i++) begin
      set_idle();
      imem_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 5) == 0);
      halt       = ($urandom_range(0, 15) == 0);
      resume     = ($urandom_range(0, 2) == 0);
      jump_en    = $urandom_range(0, 1) == 1;
      call_en    = $urandom_range(0, 2) == 0;
      ret_en     = $urandom_range(0, 2) == 0;
      jump_addr  = 16'($urandom);
      call_addr  = 16'($urandom);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  task automatic test_midreset();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      call_en = 1; call_addr = 16'h0090 + 16'(i);
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL pre_reset[%0d]: got %h want %h", i, obs, e); end
    end
    #2; reset_n = 0; model_reset(); #1;
    checks++;
    if (obs !== {16'h0000, 5'b00100}) begin
      errors++; $display("FAIL mid_reset: got %h want %h", obs, {16'h0000, 5'b00100});
    end
    @(posedge clk); #1; reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL post_reset[%0d]: got %h want %h", i, obs, e); end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_hold();
    test_call_ret();
    test_overflow();
    test_wrap();
    test_priority();
    test_halt();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
